ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
Parameters:
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clock-low inhibit time (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000, maximum clk cycles allowed before the first PS/2 clock falling edge and between any two later falling edges (15 ms).

Ports:
REQ-003 SHALL have port clk  input  1  system clock (100 MHz mclk domain).
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the device.
REQ-006 SHALL have port tx_valid  input  1  command request.
REQ-007 SHALL have port tx_ready  output  1  high in IDLE; a byte is accepted when tx_valid and tx_ready are both high.
REQ-008 SHALL have port ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous).
REQ-009 SHALL have port ps2_data_in  input  1  raw PS/2 data pin level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release.
REQ-011 SHALL have port ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse: device acknowledged the frame.
REQ-014 SHALL have port err  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; a PS/2 falling edge (fe) is synced clock 1 in the previous cycle and 0 in the current cycle.
REQ-016 SHALL latch tx_data on acceptance and build the frame {stop=1, parity, data[7:0]}; parity is odd, i.e. ~^data.
REQ-017 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, RELEASE.
REQ-018 IDLE: both oe=0; on accept, go to INHIBIT.
REQ-019 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
REQ-020 REQ: clk_oe=1, data_oe=1 (start bit) for 1 cycle, then go to SEND with clk_oe=0 and data_oe held at 1.
REQ-021 SEND: on the k-th fe (k=1..9), drive frame bit k-1 with data_oe = ~bit, so data bits go out LSB first, then parity.
REQ-022 SEND: on the 10th fe, set data_oe=0 (stop bit) and go to ACK.
REQ-023 ACK: on the next fe, sample synced data. If 0, go to RELEASE. If 1, pulse err and go to IDLE.
REQ-024 RELEASE: wait until synced clock and synced data are both 1, then pulse done and go to IDLE.
REQ-025 Timeout SHALL be measured by a counter that clears on entry to SEND and on every fe. If it reaches TIMEOUT_CYCLES in SEND, ACK or RELEASE, pulse err, release both lines, go to IDLE.
REQ-026 done and err SHALL never assert in the same cycle; each is 1 clk wide.
REQ-027 tx_valid while busy SHALL be ignored; no data is latched and no queueing takes place.
REQ-028 A new request MAY be accepted in the cycle after done or err.
REQ-029 oe outputs SHALL be registered, with no combinational path from the inputs.

Reset
REQ-030 While rst is high, the block SHALL be in IDLE with ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, tx_ready=0, counters and shift register 0.
REQ-031 tx_ready SHALL rise on the first clk edge after rst deasserts.
REQ-032 Reset asserted mid-frame SHALL release both lines immediately (asynchronously) and emit no done or err pulse.

Structure
REQ-033 Shared package ps2_pkg SHALL hold the state encoding, FRAME_BITS=11 and the default INHIBIT/TIMEOUT constants, for reuse by the mouse receive path.
REQ-034 The block SHALL contain one sub-module, ps2_sync: a 2-flop synchronizer plus fe detector, instantiated once per line.
REQ-035 Open-drain tri-stating SHALL be done at the top level, not inside this block.

Verification
REQ-036 Send 0xF4 with a bench device clocking at 12.5 kHz and ACKing -> data line shows 0,0,0,1,0,1,1,1,1,0(parity),1(stop), device ACK, one done pulse, tx_ready returns high.
REQ-037 Send 0xFF -> parity bit 1; clk_oe is low for exactly 10000 cycles before data_oe rises.
REQ-038 Device clocks all 11 edges but holds data high at the ACK edge -> one err pulse, no done, both oe=0.
REQ-039 Device never toggles the clock after REQ -> err exactly 1500000 cycles after SEND entry, both oe=0.
REQ-040 Assert rst after the 5th fe -> both oe drop in the same cycle, no done or err; after release, 0xF5 sends correctly.
REQ-041 Pulse tx_valid with 0x00 during SEND of 0xF4 -> ignored; only 0xF4 appears on the line.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 definitions for host transmit and mouse receive paths
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    RELEASE
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // 100 us and 15 ms at 100 MHz
  localparam int DEF_INHIBIT_CYCLES = 10000;
  localparam int DEF_TIMEOUT_CYCLES = 1500000;

  // PS/2 uses odd parity over the data byte
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - 2-flop synchronizer with falling-edge detect for one PS/2 line
module ps2_sync
  import ps2_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic fe_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o  = sync_q;
  assign fe_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic rdy_q;

  logic clk_s, clk_fe;
  logic data_s, data_fe_unused;
  logic accept;

  ps2_sync u_sync_clk (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (ps2_clk_in),
    .q_o   (clk_s),
    .fe_o  (clk_fe)
  );

  ps2_sync u_sync_data (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (ps2_data_in),
    .q_o   (data_s),
    .fe_o  (data_fe_unused)
  );

  assign tx_ready    = rdy_q && (state_q == IDLE);
  assign accept      = tx_valid && tx_ready;
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;

  // State and registered outputs; reset drops both lines asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdy_q     <= 1'b1;
    end
  end

  // Next-state logic: inhibit, request-to-send, shift out, check ACK, wait for bus release
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (accept) begin
          state_d   = INHIBIT;
          clk_oe_d  = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = '0;
          shift_d   = {1'b1, odd_parity(tx_data), tx_data};
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = REQ;
          data_oe_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        // release clock, keep start bit on data; device now owns the clock
        state_d  = SEND;
        clk_oe_d = 1'b0;
        cnt_d    = '0;
      end
      SEND, ACK, RELEASE: begin
        // one counter serves as the edge-to-edge watchdog for all device-clocked states
        cnt_d = clk_fe ? '0 : cnt_q + 1'b1;
        if (state_q == SEND && clk_fe) begin
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (state_q == ACK && clk_fe) begin
          if (!data_s) begin
            state_d = RELEASE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (state_q == RELEASE && clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!clk_fe && cnt_q == TMO_LAST) begin
          err_d     = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
  int inh_run = 0, inh_last = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;

  logic [10:0] exp_frame_q[$];
  int          exp_res_q[$];   // 0 = none, 1 = done, 2 = err

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) overlap_cnt++;
    if ((done && done_prev) || (err && err_prev)) wide_cnt++;
    done_prev = done;
    err_prev  = err;
    if (ps2_clk_oe && !ps2_data_oe) begin
      inh_run++;
    end else begin
      if (ps2_clk_oe && ps2_data_oe && inh_run > 0) inh_last = inh_run;
      inh_run = 0;
    end
  end

  task automatic send(input logic [7:0] d, input int res);
    int t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_idle", tx_ready, 1);
    inh_last = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    exp_frame_q.push_back(frame_of(d));
    exp_res_q.push_back(res);
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // mode 0: ACK, 1: no ACK, 2: never clock, 3: stop after 5th falling edge
  task automatic dev_run(input int mode, input bit inject, output logic [10:0] frame);
    int t = 0;
    frame = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 4 * INH) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    if (mode == 2) return;
    frame[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (mode == 3 && i == 5) return;
      dev_clk  = 1'b1;
      frame[i] = ps2_data_in;
      if (inject && i == 3) begin
        check("ready_low_busy", tx_ready, 0);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (mode == 0) dev_data = 1'b0;
    repeat (4) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    dev_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic expect_outcome(input string tag, input int d0, input int e0);
    int t = 0;
    int res;
    while (done_cnt == d0 && err_cnt == e0 && t < 4 * TMO) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    res = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : -1;
    check({tag, "_done"}, done_cnt - d0, (res == 1) ? 1 : 0);
    check({tag, "_err"}, err_cnt - e0, (res == 2) ? 1 : 0);
    check({tag, "_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check({tag, "_ready"}, tx_ready, 1);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] fr);
    logic [10:0] exp;
    exp = (exp_frame_q.size() > 0) ? exp_frame_q.pop_front() : 11'h7ff;
    check({tag, "_frame"}, fr, exp);
  endtask

  initial begin
    logic [10:0] fr;
    int d0, e0, t;

    repeat (3) @(negedge clk);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_pulses", {done, err}, 2'b00);
    check("rst_ready", tx_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1);

    // 0xF4 with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4, 1);
    dev_run(0, 1'b0, fr);
    check("f4_parity", fr[9], 0);
    check_frame("f4", fr);
    expect_outcome("f4", d0, e0);
    check("f4_inhibit_len", inh_last, INH);

    // 0xFF: parity 1, inhibit length
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF, 1);
    dev_run(0, 1'b0, fr);
    check("ff_parity", fr[9], 1);
    check_frame("ff", fr);
    expect_outcome("ff", d0, e0);
    check("ff_inhibit_len", inh_last, INH);

    // device withholds ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 2);
    dev_run(1, 1'b0, fr);
    check_frame("nack", fr);
    expect_outcome("nack", d0, e0);

    // device never clocks: timeout measured from SEND entry
    d0 = done_cnt; e0 = err_cnt;
    send(8'hAA, 2);
    dev_run(2, 1'b0, fr);
    void'(exp_frame_q.pop_front());
    t = 0;
    while (!err && t < TMO + 50) begin
      @(negedge clk);
      t++;
    end
    check("timeout_cycles", t, TMO);
    check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    expect_outcome("timeout", d0, e0);

    // request during SEND is ignored
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4, 1);
    dev_run(0, 1'b1, fr);
    check_frame("inject", fr);
    expect_outcome("inject", d0, e0);
    repeat (50) @(negedge clk);
    check("no_queued", busy, 0);

    // reset after the 5th falling edge
    d0 = done_cnt; e0 = err_cnt;
    send(8'h0F, 0);
    dev_run(3, 1'b0, fr);
    check("mid_data_oe_before", ps2_data_oe, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (3) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    rst = 1'b0;
    void'(exp_frame_q.pop_front());
    void'(exp_res_q.pop_front());
    repeat (5) @(negedge clk);
    check("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // 0xF5 after reset
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF5, 1);
    dev_run(0, 1'b0, fr);
    check_frame("f5", fr);
    expect_outcome("f5", d0, e0);

    check("pulse_overlap", overlap_cnt, 0);
    check("pulse_width", wide_cnt, 0);
    check("queues_empty", exp_frame_q.size() + exp_res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
